// File: rtl/pwm_load_scheduler.sv
// rtl/pwm_load_scheduler.sv - period-aligned round-robin duty reload sequencer for RGB PWM drivers
module pwm_load_scheduler #(
    parameter int          CHANNELS   = 6,
    parameter int          DUTY_WIDTH = 8,
    parameter logic [7:0]  PERIOD     = 8'hff
) (
    input  logic                           fast_clk,
    input  logic                           rst,
    input  logic [CHANNELS*DUTY_WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]            load,
    output logic [DUTY_WIDTH+7:0]          load_data,
    output logic [CHANNELS-1:0]            pending,
    output logic                           period_tick,
    output logic                           busy
);
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(CHANNELS + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    period_tick_q, period_tick_d;
    logic [CHANNELS-1:0]     pending_q, pending_d;
    logic [CHANNELS-1:0]     load_q, load_d;
    logic [DUTY_WIDTH+7:0]   load_data_q, load_data_d;
    logic [DUTY_WIDTH-1:0]   shadow_q [CHANNELS];
    logic [DUTY_WIDTH-1:0]   shadow_d [CHANNELS];
    logic [DUTY_WIDTH-1:0]   duty [CHANNELS];
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           issue_cnt_q, issue_cnt_d;
    logic [PW-1:0]           grant_idx, cand;
    logic                    grant_found;
    logic [CHANNELS-1:0]     grant_oh;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign duty[i] = duty_in[i*DUTY_WIDTH +: DUTY_WIDTH];
    end

    function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] base, input logic [PW-1:0] offs);
        logic [PW:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= (PW+1)'(CHANNELS)) begin
            sum = sum - (PW+1)'(CHANNELS);
        end
        return sum[PW-1:0];
    endfunction

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = rr_add(ptr_q, PW'(k));
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        load_d        = '0;
        load_data_d   = load_data_q;
        shadow_d      = shadow_q;
        ptr_d         = ptr_q;
        issue_cnt_d   = issue_cnt_q;
        grant_oh      = '0;
        cnt_d         = (cnt_q == PERIOD) ? 8'd0 : cnt_q + 8'd1;
        period_tick_d = (cnt_q == PERIOD);

        case (state_q)
            IDLE: begin
                if (period_tick_q && (|pending_q)) begin
                    state_d     = ISSUE;
                    issue_cnt_d = '0;
                end
            end
            ISSUE: begin
                if (!grant_found) begin
                    state_d = IDLE;
                end else begin
                    grant_oh            = CHANNELS'(1) << grant_idx;
                    load_d              = grant_oh;
                    load_data_d         = {duty[grant_idx], PERIOD};
                    shadow_d[grant_idx] = duty[grant_idx];
                    ptr_d               = rr_add(grant_idx, PW'(1));
                    issue_cnt_d         = issue_cnt_q + CW'(1);
                    // The count cap stops a channel that keeps changing from holding the bus.
                    if (((pending_q & ~grant_oh) == '0) || (issue_cnt_d == CW'(CHANNELS))) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < CHANNELS; i++) begin
            pending_d[i] = (duty[i] != shadow_q[i]) && !grant_oh[i];
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            period_tick_q <= 1'b0;
            pending_q     <= '0;
            load_q        <= '0;
            load_data_q   <= '0;
            ptr_q         <= '0;
            issue_cnt_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_tick_q <= period_tick_d;
            pending_q     <= pending_d;
            load_q        <= load_d;
            load_data_q   <= load_data_d;
            ptr_q         <= ptr_d;
            issue_cnt_q   <= issue_cnt_d;
            shadow_q      <= shadow_d;
        end
    end

    assign load        = load_q;
    assign load_data   = load_data_q;
    assign pending     = pending_q;
    assign period_tick = period_tick_q;
    assign busy        = (state_q == ISSUE);

endmodule

// File: tb/tb_pwm_load_scheduler.sv
// tb/tb_pwm_load_scheduler.sv - randomized and directed bench for pwm_load_scheduler
module tb_pwm_load_scheduler;
    localparam int         CH  = 6;
    localparam int         DW  = 8;
    localparam logic [7:0] PER = 8'h07;
    localparam int         OW  = CH + DW + 8 + CH + 2;

    logic                fast_clk = 1'b0;
    logic                rst      = 1'b1;
    logic [CH*DW-1:0]    duty_in  = '0;
    logic [CH-1:0]       load;
    logic [DW+7:0]       load_data;
    logic [CH-1:0]       pending;
    logic                period_tick;
    logic                busy;

    int total = 0;
    int bad   = 0;

    pwm_load_scheduler #(.CHANNELS(CH), .DUTY_WIDTH(DW), .PERIOD(PER)) dut (
        .fast_clk    (fast_clk),
        .rst         (rst),
        .duty_in     (duty_in),
        .load        (load),
        .load_data   (load_data),
        .pending     (pending),
        .period_tick (period_tick),
        .busy        (busy)
    );

    always #5 fast_clk = ~fast_clk;

    // Reference: boundary every PER+1 cycles, then a burst serving pending channels in ring order.
    int            m_cnt = 0;
    bit            m_tick = 0;
    bit [CH-1:0]   m_pend = '0;
    logic [DW-1:0] m_shadow [CH] = '{default: '0};
    int            m_ptr = 0;
    bit            m_active = 0;
    int            m_issued = 0;
    bit [CH-1:0]   m_load = '0;
    logic [DW+7:0] m_ld = '0;

    always @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_tick = 0; m_pend = '0; m_ptr = 0;
            m_active = 0; m_issued = 0; m_load = '0; m_ld = '0;
            for (int i = 0; i < CH; i++) m_shadow[i] = '0;
        end else begin
            int          g;
            bit [CH-1:0] np;
            bit          nt;
            nt = (m_cnt == int'(PER));
            g  = -1;
            if (m_active) begin
                for (int k = 0; k < CH; k++) begin
                    if (g < 0 && m_pend[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
                end
            end
            for (int i = 0; i < CH; i++) np[i] = (duty_in[i*DW +: DW] != m_shadow[i]) && (i != g);
            m_load = '0;
            if (m_active) begin
                if (g < 0) begin
                    m_active = 0;
                end else begin
                    m_load[g]   = 1'b1;
                    m_ld        = {duty_in[g*DW +: DW], PER};
                    m_shadow[g] = duty_in[g*DW +: DW];
                    m_ptr       = (g + 1) % CH;
                    m_issued    = m_issued + 1;
                    if ((m_pend & ~m_load) == '0 || m_issued == CH) m_active = 0;
                end
            end else if (m_tick && m_pend != '0) begin
                m_active = 1;
                m_issued = 0;
            end
            m_pend = np;
            m_tick = nt;
            m_cnt  = (m_cnt == int'(PER)) ? 0 : m_cnt + 1;
        end
    end

    function automatic logic [OW-1:0] obs();
        return {load, load_data, pending, period_tick, busy};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {m_load, m_ld, m_pend, m_tick, m_active};
    endfunction

    task automatic set_duty(input int ch, input logic [DW-1:0] v);
        duty_in[ch*DW +: DW] = v;
    endtask

    task automatic test_reset();
        @(negedge fast_clk);
        @(negedge fast_clk);
        total++; if (load !== '0) begin bad++; $display("FAIL reset_load got=%b want=0", load); end
        total++; if (load_data !== '0) begin bad++; $display("FAIL reset_load_data got=%h want=0", load_data); end
        total++; if (pending !== '0) begin bad++; $display("FAIL reset_pending got=%b want=0", pending); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", period_tick); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int last = -1;
        int loads = 0;
        int ticks = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL idle_c%0d got=%h want=%h", c, obs(), expv()); end
            if (load !== '0) loads++;
            if (period_tick === 1'b1) begin
                if (last >= 0) begin
                    total++; if (c - last !== int'(PER) + 1) begin bad++; $display("FAIL idle_tick_gap got=%0d want=%0d", c - last, int'(PER) + 1); end
                end
                last = c;
                ticks++;
            end
        end
        total++; if (loads !== 0) begin bad++; $display("FAIL idle_loads got=%0d want=0", loads); end
        total++; if (ticks < 12) begin bad++; $display("FAIL idle_ticks got=%0d want>=12", ticks); end
    endtask

    task automatic test_single();
        int last_tick = -1;
        int tick_at_load = -1;
        int nload = 0;
        logic [CH-1:0] l0 = '0;
        logic [DW+7:0] d0 = '0;
        set_duty(2, 8'h80);
        @(negedge fast_clk);
        total++; if (pending !== 6'b000100) begin bad++; $display("FAIL single_pending got=%b want=000100", pending); end
        for (int c = 0; c < 20; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL single_c%0d got=%h want=%h", c, obs(), expv()); end
            if (period_tick === 1'b1) last_tick = c;
            if (load !== '0) begin
                nload++; l0 = load; d0 = load_data;
                tick_at_load = c - last_tick;
            end
        end
        total++; if (nload !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", nload); end
        total++; if (l0 !== 6'b000100) begin bad++; $display("FAIL single_load got=%b want=000100", l0); end
        total++; if (d0 !== 16'h8007) begin bad++; $display("FAIL single_data got=%h want=8007", d0); end
        total++; if (tick_at_load !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", tick_at_load); end
        total++; if (pending !== '0) begin bad++; $display("FAIL single_pending_end got=%b want=0", pending); end
    endtask

    task automatic test_multi();
        logic [CH-1:0] lq[$];
        logic [DW+7:0] dq[$];
        int lc[$];
        int busy_n = 0;
        logic [CH-1:0] el [3] = '{6'b000001, 6'b001000, 6'b100000};
        logic [DW+7:0] ed [3] = '{16'h1007, 16'h2007, 16'h3007};
        set_duty(5, 8'h01);
        for (int c = 0; c < 20; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL multi_pre_c%0d got=%h want=%h", c, obs(), expv()); end
        end
        set_duty(0, 8'h10); set_duty(3, 8'h20); set_duty(5, 8'h30);
        for (int c = 0; c < 20; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL multi_c%0d got=%h want=%h", c, obs(), expv()); end
            if (busy === 1'b1) busy_n++;
            if (load !== '0) begin lq.push_back(load); dq.push_back(load_data); lc.push_back(c); end
        end
        total++; if (lq.size() !== 3) begin bad++; $display("FAIL multi_count got=%0d want=3", lq.size()); end
        total++; if (busy_n !== 3) begin bad++; $display("FAIL multi_busy got=%0d want=3", busy_n); end
        for (int i = 0; i < 3 && i < lq.size(); i++) begin
            total++; if (lq[i] !== el[i] || dq[i] !== ed[i]) begin bad++; $display("FAIL multi_load%0d got=%b/%h want=%b/%h", i, lq[i], dq[i], el[i], ed[i]); end
        end
        if (lc.size() == 3) begin
            total++; if (lc[2] - lc[0] !== 2) begin bad++; $display("FAIL multi_consecutive got=%0d want=2", lc[2] - lc[0]); end
        end
    endtask

    task automatic test_rr_wrap();
        logic [CH-1:0] lq[$];
        logic [DW+7:0] dq[$];
        set_duty(3, 8'h21);
        for (int c = 0; c < 20; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rr_pre_c%0d got=%h want=%h", c, obs(), expv()); end
        end
        set_duty(1, 8'h41); set_duty(4, 8'h44);
        for (int c = 0; c < 20; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rr_c%0d got=%h want=%h", c, obs(), expv()); end
            if (load !== '0) begin lq.push_back(load); dq.push_back(load_data); end
        end
        set_duty(1, 8'h42); set_duty(3, 8'h23);
        for (int c = 0; c < 20; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rr_post_c%0d got=%h want=%h", c, obs(), expv()); end
            if (load !== '0) begin lq.push_back(load); dq.push_back(load_data); end
        end
        total++; if (lq.size() !== 4) begin bad++; $display("FAIL rr_count got=%0d want=4", lq.size()); end
        if (lq.size() == 4) begin
            total++; if ({lq[0], lq[1]} !== {6'b010000, 6'b000010}) begin bad++; $display("FAIL rr_order got=%b,%b want=010000,000010", lq[0], lq[1]); end
            total++; if ({dq[0], dq[1]} !== {16'h4407, 16'h4107}) begin bad++; $display("FAIL rr_data got=%h,%h want=4407,4107", dq[0], dq[1]); end
            total++; if ({lq[2], lq[3]} !== {6'b001000, 6'b000010}) begin bad++; $display("FAIL rr_ptr2_order got=%b,%b want=001000,000010", lq[2], lq[3]); end
        end
    endtask

    task automatic test_reset_mid_issue();
        logic [CH-1:0] lq[$];
        logic [DW+7:0] dq[$];
        bit seen = 0;
        for (int i = 0; i < CH; i++) set_duty(i, 8'h00);
        for (int c = 0; c < 20; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rmid_flush_c%0d got=%h want=%h", c, obs(), expv()); end
        end
        set_duty(0, 8'h11); set_duty(3, 8'h22); set_duty(5, 8'h33);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rmid_wait_c%0d got=%h want=%h", c, obs(), expv()); end
            if (load !== '0) seen = 1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rmid_timeout got=%b want=1", seen); end
        #1 rst = 1'b1;
        #1;
        total++; if ({load, busy, pending} !== '0) begin bad++; $display("FAIL rmid_async got=%b/%b/%b want=0", load, busy, pending); end
        #2 rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rmid_c%0d got=%h want=%h", c, obs(), expv()); end
            if (load !== '0) begin lq.push_back(load); dq.push_back(load_data); end
        end
        total++; if (lq.size() !== 3) begin bad++; $display("FAIL rmid_count got=%0d want=3", lq.size()); end
        if (lq.size() == 3) begin
            total++; if ({lq[0], lq[1], lq[2]} !== {6'b000001, 6'b001000, 6'b100000}) begin bad++; $display("FAIL rmid_order got=%b,%b,%b", lq[0], lq[1], lq[2]); end
            total++; if ({dq[0], dq[1], dq[2]} !== {16'h1107, 16'h2207, 16'h3307}) begin bad++; $display("FAIL rmid_data got=%h,%h,%h", dq[0], dq[1], dq[2]); end
        end
    endtask

    task automatic test_random();
        int last_tick = -1;
        int burst_loads = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge fast_clk);
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rand_c%0d got=%h want=%h", c, obs(), expv()); end
            if (period_tick === 1'b1) begin last_tick = c; burst_loads = 0; end
            if (load !== '0) begin
                burst_loads++;
                total++; if ($countones(load) !== 1) begin bad++; $display("FAIL rand_onehot got=%b want=onehot", load); end
                total++; if (burst_loads > CH) begin bad++; $display("FAIL rand_burst got=%0d want<=%0d", burst_loads, CH); end
                if (last_tick >= 0) begin
                    total++; if (c - last_tick < 2 || c - last_tick > CH + 1) begin bad++; $display("FAIL rand_window got=%0d want=2..%0d", c - last_tick, CH + 1); end
                end
            end
            set_duty(0, DW'($urandom));
            for (int i = 1; i < CH; i++) begin
                if ($urandom_range(0, 3) == 0) set_duty(i, DW'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_multi();
        test_rr_wrap();
        test_reset_mid_issue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
